led_seq_ctrl: RTL and testbench
===============================

Name: led_seq_ctrl

Overview:
Multi-channel LED sequencer that drives C_NUM_LEDS board LEDs from one shared time base. Each channel holds a mode (off, on, slow blink, fast blink, counted burst), loaded through a valid/ready config port from the control logic or register bank. It sits between the system status logic and the LED pins, replacing the per-LED free-running blinkers.

Parameters:
C_CLK_FREQ, 100000000, clk frequency in Hz (documentation and derived default only)
C_TICK_DIV, C_CLK_FREQ/10, clk cycles per shared tick (100 ms at default); minimum 2
C_NUM_LEDS, 4, number of LED channels; range 1..16
C_LED_ON, 1, pin level for a lit LED; unlit level is ~C_LED_ON

Ports:
clk  in  1  system clock
rst  in  1  reset
cfg_valid  in  1  config write request
cfg_ready  out  1  config accept; write occurs when cfg_valid && cfg_ready
cfg_ch  in  CH_W=max(1,$clog2(C_NUM_LEDS))  target channel
cfg_mode  in  3  0 OFF, 1 ON, 2 SLOW, 3 FAST, 4 BURST, 5-7 reserved
cfg_count  in  4  burst flash count (BURST only)
led  out  C_NUM_LEDS  LED pins, registered
burst_done  out  C_NUM_LEDS  1-cycle pulse per channel when a burst completes
cfg_err  out  1  1-cycle pulse when an accepted write is rejected

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. During reset and the cycle it deasserts: led = all ~C_LED_ON, burst_done = 0, cfg_err = 0, cfg_ready = 0. All modes = OFF, prescaler = 0, phase = 0. cfg_ready = 1 from the second cycle after rst deasserts and stays 1.
- Prescaler: counts 0..C_TICK_DIV-1 and wraps. tick = 1 for the single cycle where the count equals C_TICK_DIV-1.
- Phase counter: 0..9. Increments on tick; 9 wraps to 0.
- Steady modes, with led registered from the current mode/phase:
  - OFF: unlit.
  - ON: lit.
  - SLOW: lit when phase<5 (1 Hz, 50 %).
  - FAST: lit when phase is even (5 Hz, 50 %).
  - SLOW and FAST stay phase-aligned across channels.
- Write latency: a write accepted at cycle T updates the mode register at T+1. led reflects the new mode at T+1.
- Write rejection: if cfg_ch >= C_NUM_LEDS or cfg_mode >= 5, there is no state change and cfg_err pulses at T+1.
- Burst FSM, per channel: IDLE, B_ON, B_OFF.
  - Accepted BURST write with N = cfg_count > 0: remaining = N, go to B_ON (lit at T+1).
  - B_ON, on tick: go to B_OFF (unlit).
  - B_OFF, on tick: remaining-1. If the result is 0, the mode becomes OFF, the FSM returns to IDLE and burst_done pulses in that same cycle. Otherwise go to B_ON.
  - The first B_ON interval is 1..C_TICK_DIV cycles because it is aligned to the shared tick. Later intervals are exactly C_TICK_DIV.
  - BURST with N = 0: mode becomes OFF and burst_done pulses at T+1. No flash.
- Write to a channel in mid-burst: the burst aborts with no burst_done, and the new mode applies at T+1. A BURST write restarts with the new N.
- Write and tick in the same cycle: the write wins for the target channel. The tick still advances the phase and the other channels.
- Reset mid-burst: aborts silently with no burst_done.
- The remaining counter is 4 bits and never underflows.

Decomposition:
- Package led_seq_pkg holds:
  - mode encodings MODE_OFF..MODE_BURST
  - burst state encodings
  - PHASE_MAX = 9, SLOW_ON_PHASES = 5
- Sub-module led_seq_channel: one per channel, generated.
  - Inputs: tick, phase, write strobe, mode, count.
  - Holds the mode register, burst FSM and remaining counter.
  - Outputs: led bit and burst_done.
- The top level holds the prescaler, phase counter, cfg decode/error and ready logic.

Test Plan (C_TICK_DIV=4, C_NUM_LEDS=4, C_LED_ON=1 unless stated):
- Reset release: rst high 5 cycles -> led=4'b0000, cfg_ready=0 through the first cycle after release, then 1; tick period is exactly 4 cycles.
- SLOW/FAST: write ch0 SLOW, ch1 FAST -> over 40 cycles ch0 is lit for phases 0-4 (20 cycles) and unlit for 5-9; ch1 toggles every 4 cycles and stays aligned to phase.
- BURST N=3 on ch2 -> exactly 3 lit intervals, burst_done[2] pulses once on the tick ending the third off interval, then ch2 stays unlit and its mode reads back as OFF.
- Abort: BURST N=5 on ch3, then write ON mid-burst -> led[3]=1 at T+1 and stays 1, no burst_done[3]; a BURST write with N=0 -> burst_done pulses at T+1.
- Errors: write cfg_ch=4 or cfg_mode=6 -> cfg_err pulses at T+1, led unchanged. Separately, a write landing on the tick cycle -> the new mode is applied and the phase still increments.
- Reset mid-burst plus polarity: with C_LED_ON=0, assert rst during B_ON -> led=4'b1111 the next cycle, no burst_done.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared encodings and constants for the LED sequencer.
package led_seq_pkg;

  typedef enum logic [2:0] {
    MODE_OFF   = 3'd0,
    MODE_ON    = 3'd1,
    MODE_SLOW  = 3'd2,
    MODE_FAST  = 3'd3,
    MODE_BURST = 3'd4
  } mode_t;

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_ON   = 2'd1,
    B_OFF  = 2'd2
  } burst_state_t;

  localparam int                 PHASE_W        = 4;
  localparam logic [PHASE_W-1:0] PHASE_MAX      = 4'd9;
  localparam logic [PHASE_W-1:0] SLOW_ON_PHASES = 4'd5;

  // Encodings 5..7 are reserved and must be rejected.
  function automatic logic mode_is_valid(input logic [2:0] m);
    return m <= 3'd4;
  endfunction

endpackage

// File: rtl/led_seq_channel.sv
// One LED channel: mode register, burst FSM and remaining-flash counter.
// The led pin is registered from the next mode/phase so a write or a tick
// is visible on the pin in the cycle right after it happens.
module led_seq_channel
  import led_seq_pkg::*;
#(
  parameter logic C_LED_ON = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [PHASE_W-1:0] phase_nxt,
  input  logic               wr,
  input  logic [2:0]         mode,
  input  logic [3:0]         count,
  output logic               led,
  output logic               burst_done
);

  mode_t        mode_q, mode_d;
  burst_state_t state_q, state_d;
  logic [3:0]   rem_q, rem_d;
  logic         done_d;
  logic         lit_d;

  // Next mode, burst state, remaining count and lit level.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    mode_d  = mode_q;
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    if (wr) begin
      // A write always wins over a coincident tick and aborts any burst.
      state_d = B_IDLE;
      rem_d   = '0;
      if (mode == MODE_BURST) begin
        if (count == 4'd0) begin
          mode_d = MODE_OFF;
          done_d = 1'b1;
        end else begin
          mode_d  = MODE_BURST;
          state_d = B_ON;
          rem_d   = count;
        end
      end else begin
        mode_d = mode_t'(mode);
      end
    end else if (tick) begin
      case (state_q)
        B_ON:  state_d = B_OFF;
        B_OFF: begin
          // rem_q is never 0 here; the <= guard keeps the counter from wrapping.
          if (rem_q <= 4'd1) begin
            mode_d  = MODE_OFF;
            state_d = B_IDLE;
            rem_d   = '0;
            done_d  = 1'b1;
          end else begin
            rem_d   = rem_q - 4'd1;
            state_d = B_ON;
          end
        end
        default: ;
      endcase
    end

    case (mode_d)
      MODE_ON:    lit_d = 1'b1;
      MODE_SLOW:  lit_d = (phase_nxt < SLOW_ON_PHASES);
      MODE_FAST:  lit_d = ~phase_nxt[0];
      MODE_BURST: lit_d = (state_d == B_ON);
      default:    lit_d = 1'b0;
    endcase
  end

  // Channel state register with synchronous reset to unlit/OFF.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_OFF;
      state_q    <= B_IDLE;
      rem_q      <= '0;
      led        <= ~C_LED_ON;
      burst_done <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      state_q    <= state_d;
      rem_q      <= rem_d;
      led        <= lit_d ? C_LED_ON : ~C_LED_ON;
      burst_done <= done_d;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer top: shared prescaler/phase time base, config port decode,
// error reporting and one led_seq_channel per LED.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int   C_CLK_FREQ = 100000000,
  parameter int   C_TICK_DIV = C_CLK_FREQ / 10,
  parameter int   C_NUM_LEDS = 4,
  parameter logic C_LED_ON   = 1'b1,
  localparam int  CH_W       = (C_NUM_LEDS > 1) ? $clog2(C_NUM_LEDS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [2:0]            cfg_mode,
  input  logic [3:0]            cfg_count,
  output logic [C_NUM_LEDS-1:0] led,
  output logic [C_NUM_LEDS-1:0] burst_done,
  output logic                  cfg_err
);

  localparam int             PRE_W    = $clog2(C_TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(C_TICK_DIV - 1);

  logic [PRE_W-1:0]      presc_q;
  logic                  tick;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic                  accept, bad;
  logic [C_NUM_LEDS-1:0] wr;

  assign tick   = (presc_q == PRE_LAST);
  assign accept = cfg_valid && cfg_ready;

  // Next phase, write decode and per-channel write strobes.
  always_comb begin
    phase_d = phase_q;
    if (tick) phase_d = (phase_q == PHASE_MAX) ? '0 : phase_q + 4'd1;
    bad = (int'(cfg_ch) >= C_NUM_LEDS) || !mode_is_valid(cfg_mode);
    wr  = '0;
    for (int i = 0; i < C_NUM_LEDS; i++) begin
      wr[i] = accept && !bad && (int'(cfg_ch) == i);
    end
  end

  // Time base, ready and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      phase_q   <= '0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      presc_q   <= tick ? '0 : presc_q + 1'b1;
      phase_q   <= phase_d;
      cfg_ready <= 1'b1;
      cfg_err   <= accept && bad;
    end
  end

  for (genvar i = 0; i < C_NUM_LEDS; i++) begin : g_ch
    led_seq_channel #(
      .C_LED_ON (C_LED_ON)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .phase_nxt  (phase_d),
      .wr         (wr[i]),
      .mode       (cfg_mode),
      .count      (cfg_count),
      .led        (led[i]),
      .burst_done (burst_done[i])
    );
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed, scoreboard-driven bench for led_seq_ctrl. dut is the default
// polarity with 4 channels; dut2 is active-low with 3 channels so that an
// out-of-range channel index is reachable on a 2-bit cfg_ch.
module tb_led_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1, rst2 = 1'b1;
  logic       valid = 1'b0, valid2 = 1'b0;
  logic [1:0] ch = '0;
  logic [2:0] mode = '0;
  logic [3:0] cnt = '0;

  logic       ready, err, ready2, err2;
  logic [3:0] led, done;
  logic [2:0] led2, done2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  led_seq_ctrl #(.C_TICK_DIV(4), .C_NUM_LEDS(4), .C_LED_ON(1'b1)) dut (
    .clk(clk), .rst(rst), .cfg_valid(valid), .cfg_ready(ready), .cfg_ch(ch),
    .cfg_mode(mode), .cfg_count(cnt), .led(led), .burst_done(done), .cfg_err(err)
  );

  led_seq_ctrl #(.C_TICK_DIV(4), .C_NUM_LEDS(3), .C_LED_ON(1'b0)) dut2 (
    .clk(clk), .rst(rst2), .cfg_valid(valid2), .cfg_ready(ready2), .cfg_ch(ch),
    .cfg_mode(mode), .cfg_count(cnt), .led(led2), .burst_done(done2), .cfg_err(err2)
  );

  always #5 clk = ~clk;

  // Bench-side cycle index: prescaler of dut equals cyc % 4.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int phase_of(input int c);
    return (c / 4) % 10;
  endfunction

  task automatic push(input string tag, input logic [31:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %0h required %0h", t, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] c, input logic [2:0] m, input logic [3:0] n);
    ch = c; mode = m; cnt = n; valid = 1'b1;
    step();
    valid = 1'b0;
  endtask

  task automatic wr2(input logic [1:0] c, input logic [2:0] m, input logic [3:0] n);
    ch = c; mode = m; cnt = n; valid2 = 1'b1;
    step();
    valid2 = 1'b0;
  endtask

  initial begin : stim
    int c1, l1, lit_n, rise_n, done_n, done_at, other_done, unlit_n, ph0, n;
    logic prev;

    // ---- reset ----
    repeat (5) step();
    push("reset_outputs", {26'd0, 4'b0000, 1'b0, 1'b0});
    pop_check({26'd0, led, ready, err});
    push("reset_done", 32'd0);
    pop_check({28'd0, done});
    push("reset_led2", 32'h7);
    pop_check({29'd0, led2});
    rst = 1'b0; rst2 = 1'b0;
    push("ready_release_cycle", 32'd0);
    pop_check({31'd0, ready});
    push("led_release_cycle", 32'd0);
    pop_check({28'd0, led});
    step();
    push("ready_after_release", 32'd1);
    pop_check({31'd0, ready});
    for (int i = 0; i < 8; i++) begin
      push("tick_period", {31'd0, (cyc % 4) == 3});
      pop_check({31'd0, dut.tick});
      step();
    end

    // ---- SLOW on ch0, FAST on ch1 ----
    wr(2'd0, 3'd2, 4'd0);
    wr(2'd1, 3'd3, 4'd0);
    lit_n = 0;
    for (int i = 0; i < 40; i++) begin
      push("slow_fast", {30'd0, phase_of(cyc) % 2 == 0, phase_of(cyc) < 5});
      pop_check({30'd0, led[1:0]});
      if (led[0]) lit_n++;
      step();
    end
    push("slow_lit_cycles", 32'd20);
    pop_check(lit_n);
    wr(2'd0, 3'd0, 4'd0);
    wr(2'd1, 3'd0, 4'd0);

    // ---- BURST N=3 on ch2 ----
    wr(2'd2, 3'd4, 4'd3);
    c1 = cyc;
    l1 = 4 - (c1 % 4);
    lit_n = 0; rise_n = 0; done_n = 0; done_at = -1; other_done = 0; prev = 1'b0;
    push("burst_lit_cycles", l1 + 8);
    push("burst_intervals", 32'd3);
    push("burst_done_count", 32'd1);
    push("burst_done_cycle", c1 + l1 + 20);
    push("burst_other_done", 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (led[2]) lit_n++;
      if (led[2] && !prev) rise_n++;
      prev = led[2];
      if (done[2]) begin
        done_n++;
        if (done_at < 0) done_at = cyc;
      end
      if (done[3] || done[1] || done[0]) other_done++;
      step();
    end
    pop_check(lit_n);
    pop_check(rise_n);
    pop_check(done_n);
    pop_check(done_at);
    pop_check(other_done);
    push("burst_end_led", 32'd0);
    pop_check({31'd0, led[2]});
    push("burst_end_mode", 32'd0);
    pop_check({29'd0, dut.g_ch[2].u_ch.mode_q});

    // ---- abort BURST on ch3 with ON ----
    wr(2'd3, 3'd4, 4'd5);
    repeat (6) step();
    wr(2'd3, 3'd1, 4'd0);
    push("abort_on_led", 32'd1);
    pop_check({31'd0, led[3]});
    unlit_n = 0; done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!led[3]) unlit_n++;
      if (done[3]) done_n++;
      step();
    end
    push("abort_unlit_cycles", 32'd0);
    pop_check(unlit_n);
    push("abort_no_done", 32'd0);
    pop_check(done_n);
    wr(2'd3, 3'd4, 4'd0);
    push("burst_n0_done", {28'd0, 4'b1000});
    pop_check({28'd0, done});
    push("burst_n0_led", 32'd0);
    pop_check({31'd0, led[3]});
    step();
    push("burst_n0_pulse_end", 32'd0);
    pop_check({28'd0, done});

    // ---- rejected writes ----
    wr(2'd1, 3'd1, 4'd0);
    push("valid_write_no_err", 32'd0);
    pop_check({31'd0, err});
    wr(2'd0, 3'd6, 4'd0);
    push("err_mode6", {26'd0, 4'b0010, 1'b1, 1'b0});
    pop_check({26'd0, led, err, err2});
    step();
    push("err_pulse_end", 32'd0);
    pop_check({31'd0, err});
    wr2(2'd3, 3'd1, 4'd0);
    push("err_ch3_dut2", {28'd0, 3'b111, 1'b1});
    pop_check({28'd0, led2, err2});

    // ---- write landing on the tick cycle ----
    n = 0;
    while ((cyc % 4) != 3 && n < 8) begin
      step();
      n++;
    end
    push("tick_align_bound", 32'd1);
    pop_check({31'd0, (cyc % 4) == 3});
    ph0 = phase_of(cyc);
    wr(2'd0, 3'd1, 4'd0);
    push("tick_write_led", {28'd0, 4'b0011});
    pop_check({28'd0, led});
    push("tick_write_phase", (ph0 + 1) % 10);
    pop_check({28'd0, dut.phase_q});

    // ---- reset mid-burst, active-low pins ----
    wr2(2'd0, 3'd4, 4'd2);
    push("dut2_burst_on", 32'h6);
    pop_check({29'd0, led2});
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    push("dut2_reset_led", 32'h7);
    pop_check({29'd0, led2});
    unlit_n = 0; done_n = 0;
    for (int i = 0; i < 30; i++) begin
      if (led2 != 3'b111) unlit_n++;
      if (done2 != 3'b000) done_n++;
      step();
    end
    push("dut2_reset_no_done", 32'd0);
    pop_check(done_n);
    push("dut2_reset_stays_unlit", 32'd0);
    pop_check(unlit_n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
